secuenciador_leds: RTL
======================

Name: secuenciador_leds

Overview:
Records up to DEPTH snapshots of the 8-bit DIP switches on debounced button presses and shows them on the LEDs. In playback it steps through the stored snapshots on a fixed dwell period and loops. It replaces the single-shot switch-to-LED capture path on the board top level. It owns button conditioning, the snapshot buffer and the display sequencing.

Parameters:
DEPTH, 8, number of snapshot slots (>=2)
DEBOUNCE_CYC, 500000, consecutive stable samples (10 ms at 50 MHz) required to accept a button level
DWELL_CYC, 25000000, cycles each snapshot is shown during playback (0.5 s at 50 MHz)

Ports:
clk  input  1  system clock, 50 MHz, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
btn_captura  input  1  raw capture button, active-high, asynchronous
btn_reproducir  input  1  raw play/stop toggle button, active-high, asynchronous
btn_borrar  input  1  raw clear button, active-high, asynchronous
dipsw  input  8  DIP switch value, sampled on the capture pulse
leds  output  8  displayed value
cuenta  output  $clog2(DEPTH+1)  number of stored snapshots
lleno  output  1  high when cuenta == DEPTH
reproduciendo  output  1  high while in state REPRODUCE

Behaviour:
- Reset is synchronous, active-low, one clock with clk. On any rst_n=0 edge: leds=0, cuenta=0, lleno=0, reproduciendo=0, state=ESPERA, dwell timer=0, play index=0.
- Reset also forces debounced levels and edge history to 0. Buffer RAM is not reset; it is unreachable while cuenta=0.
- Button conditioning, per button:
  - 2-FF synchroniser.
  - Debounce counter: accepts a new level after DEBOUNCE_CYC consecutive equal synchronised samples that differ from the current level. Any mismatch restarts the count.
  - A 0->1 transition of the debounced level gives a 1-cycle pulse.
  - Release is debounced the same way and produces no pulse. A held button gives exactly one pulse.
- Pulse priority in the same cycle: borrar > reproducir > captura. Lower-priority pulses in that cycle are dropped.
- State ESPERA (reproduciendo=0):
  - captura pulse with cuenta<DEPTH: mem[cuenta]<=dipsw, cuenta++, leds<=dipsw. All take effect at the next edge (1-cycle latency from pulse).
  - captura pulse with cuenta==DEPTH: ignored; nothing changes.
  - reproducir pulse with cuenta==0: ignored.
  - reproducir pulse with cuenta>0: go to REPRODUCE, index=0, leds<=mem[0], timer=0.
- State REPRODUCE (reproduciendo=1):
  - Timer increments each cycle. At timer==DWELL_CYC-1: timer=0, index advances, leds<=mem[new index].
  - Index wraps from cuenta-1 to 0. With cuenta==1, leds stays mem[0].
  - Each entry is therefore visible for exactly DWELL_CYC cycles.
  - captura pulses are ignored (cuenta frozen).
  - reproducir pulse: go to ESPERA, leds<=mem[cuenta-1], timer=0.
- borrar pulse, any state: cuenta=0, state=ESPERA, leds=0, timer=0, index=0.
- lleno = (cuenta==DEPTH), combinational from the cuenta register. reproduciendo is decoded from the state register.
- Widths:
  - index: $clog2(DEPTH) bits.
  - timer: $clog2(DWELL_CYC) bits.
  - debounce counter: $clog2(DEBOUNCE_CYC+1) bits.
  - No counter may wrap except the explicit index wrap.
- Press-to-effect latency: 2 sync cycles + DEBOUNCE_CYC + 1 edge-detect cycle + 1 cycle to register the outputs. The bench checks this exact count.

Decomposition:
- Package secuenciador_pkg:
  - state enum {ESPERA, REPRODUCE}, 1-bit encoding.
  - localparam LED_W=8.
  - width helper constants derived from the parameters.
- Sub-module antirrebote:
  - Parameter DEBOUNCE_CYC.
  - Ports clk, rst_n, btn_in, nivel, pulso.
  - Instantiated three times.
- Buffer: DEPTH x 8 register array inside the top. Write on capture only, one asynchronous read port.

Test Plan (DEPTH=4, DEBOUNCE_CYC=4, DWELL_CYC=3):
1. Release reset, dipsw=0xA5, hold btn_captura 10 cycles -> exactly one capture. Cycle count from press matches the stated latency; leds=0xA5, cuenta=1, lleno=0.
2. btn_captura glitch high 3 cycles, then low -> no pulse, cuenta unchanged. Pulse bursts high 2 / low 1 / high 2 -> no capture.
3. Capture 0x01,0x02,0x04,0x08, then 0xFF -> cuenta=4, lleno=1, leds=0x08. The 5th capture leaves cuenta and leds unchanged.
4. Press reproducir -> reproduciendo=1. leds runs 0x01 x3 cycles, 0x02 x3, 0x04 x3, 0x08 x3, then 0x01 (wrap). A captura press mid-playback leaves cuenta=4.
5. Press reproducir again -> reproduciendo=0, leds=0x08. Pulse borrar and reproducir in the same cycle -> borrar wins: cuenta=0, leds=0x00, lleno=0. A following reproducir with cuenta=0 is ignored.
6. Hold rst_n=0 for one edge mid-playback -> at that edge leds=0, cuenta=0, reproduciendo=0. A button held across reset produces no pulse until it is released and pressed again.

Source files
------------

// File: rtl/secuenciador_pkg.sv
// Shared types and width helpers for the LED snapshot sequencer.
package secuenciador_pkg;

  localparam int unsigned LED_W = 8;

  typedef enum logic [0:0] {
    StEspera    = 1'b0,
    StReproduce = 1'b1
  } estado_e;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned ancho(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/antirrebote.sv
// Button conditioner: 2-FF synchroniser, level debouncer and rising-edge pulse.
module antirrebote #(
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic nivel,
  output logic pulso
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);

  logic            sync1_q, sync2_q;
  logic            nivel_q, prev_q, armado_q, pulso_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    sync1_q <= btn_in;
    sync2_q <= sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nivel_q  <= 1'b0;
      prev_q   <= 1'b0;
      armado_q <= 1'b0;
      pulso_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // A rise only counts once the button has been seen released since reset.
      armado_q <= armado_q | ~sync2_q;
      prev_q   <= nivel_q;
      pulso_q  <= nivel_q & ~prev_q & armado_q;
      if (sync2_q == nivel_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
        nivel_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign nivel = nivel_q;
  assign pulso = pulso_q;

endmodule

// File: rtl/secuenciador_leds.sv
// Records DIP-switch snapshots on button presses and replays them on the LEDs in a loop.
module secuenciador_leds
  import secuenciador_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned DWELL_CYC    = 25000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       btn_captura,
  input  logic                       btn_reproducir,
  input  logic                       btn_borrar,
  input  logic [LED_W-1:0]           dipsw,
  output logic [LED_W-1:0]           leds,
  output logic [$clog2(DEPTH+1)-1:0] cuenta,
  output logic                       lleno,
  output logic                       reproduciendo
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = ancho(DEPTH);
  localparam int unsigned TW = ancho(DWELL_CYC);

  logic p_cap, p_rep, p_bor;
  logic n_cap, n_rep, n_bor;
  logic unused_niveles;

  antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_captura (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_in(btn_captura),
    .nivel (n_cap),
    .pulso (p_cap)
  );

  antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_reproducir (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_in(btn_reproducir),
    .nivel (n_rep),
    .pulso (p_rep)
  );

  antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_borrar (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_in(btn_borrar),
    .nivel (n_bor),
    .pulso (p_bor)
  );

  assign unused_niveles = n_cap ^ n_rep ^ n_bor;

  estado_e          estado_q;
  logic [CW-1:0]    cuenta_q;
  logic [LED_W-1:0] leds_q;
  logic [TW-1:0]    timer_q;
  logic [IW-1:0]    idx_q, idx_sig;
  logic [LED_W-1:0] mem_q [DEPTH];
  logic             lleno_w, wr_en;

  assign lleno_w = (cuenta_q == CW'(DEPTH));
  assign wr_en   = rst_n & p_cap & ~p_rep & ~p_bor & (estado_q == StEspera) & ~lleno_w;
  assign idx_sig = (CW'(idx_q) == cuenta_q - 1'b1) ? '0 : idx_q + 1'b1;

  // Snapshot buffer is intentionally not reset; it is unreachable while cuenta is zero.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[IW'(cuenta_q)] <= dipsw;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= StEspera;
      cuenta_q <= '0;
      leds_q   <= '0;
      timer_q  <= '0;
      idx_q    <= '0;
    end else if (p_bor) begin
      estado_q <= StEspera;
      cuenta_q <= '0;
      leds_q   <= '0;
      timer_q  <= '0;
      idx_q    <= '0;
    end else begin
      unique case (estado_q)
        StEspera: begin
          if (p_rep) begin
            if (cuenta_q != '0) begin
              estado_q <= StReproduce;
              idx_q    <= '0;
              leds_q   <= mem_q[IW'(0)];
              timer_q  <= '0;
            end
          end else if (p_cap && !lleno_w) begin
            cuenta_q <= cuenta_q + 1'b1;
            leds_q   <= dipsw;
          end
        end
        StReproduce: begin
          if (p_rep) begin
            estado_q <= StEspera;
            leds_q   <= mem_q[IW'(cuenta_q - 1'b1)];
            timer_q  <= '0;
          end else if (timer_q == TW'(DWELL_CYC - 1)) begin
            timer_q <= '0;
            idx_q   <= idx_sig;
            leds_q  <= mem_q[idx_sig];
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign leds          = leds_q;
  assign cuenta        = cuenta_q;
  assign lleno         = lleno_w;
  assign reproduciendo = (estado_q == StReproduce);

endmodule
